// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between NUM_REQ requesters,
// with illegal-mode filtering and a watchdog that resets a hung ALU.
//   state | meaning
//   IDLE  | scan requests from rr_ptr, accept one and latch its operands
//   ISSUE | one-cycle alu_valid pulse, arm the watchdog
//   WAIT  | wait for alu_ready or watchdog expiry
//   RESP  | one-cycle resp_valid to the granted requester
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [32*NUM_REQ-1:0] req_a_i,
    input  logic [32*NUM_REQ-1:0] req_b_i,
    input  logic [4*NUM_REQ-1:0]  req_mode_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [NUM_REQ-1:0]    resp_valid_o,
    output logic [63:0]           resp_data_o,
    output logic                  resp_err_o,
    output logic                  alu_valid_o,
    output logic [31:0]           alu_a_o,
    output logic [31:0]           alu_b_o,
    output logic [3:0]            alu_mode_o,
    output logic                  alu_rst_n_o,
    input  logic                  alu_ready_i,
    input  logic [63:0]           alu_out_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [31:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]         alu_mode_q, alu_mode_d;
    logic [63:0]        data_q, data_d;
    logic               err_q, err_d;
    logic               tout_q, tout_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;

    logic [31:0]        a_arr [NUM_REQ];
    logic [31:0]        b_arr [NUM_REQ];
    logic [3:0]         mode_arr [NUM_REQ];
    logic [IDX_W-1:0]   cand_idx, scan_idx;
    logic               cand_found, cand_legal, handshake;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign a_arr[i]    = req_a_i[32*i +: 32];
        assign b_arr[i]    = req_b_i[32*i +: 32];
        assign mode_arr[i] = req_mode_i[4*i +: 4];
    end

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!cand_found && req_valid_i[scan_idx]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx;
            end
        end
    end

    assign cand_legal = (mode_arr[cand_idx] <= 4'd10);
    assign handshake  = (state_q == S_IDLE) && cand_found && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (handshake) state_d = cand_legal ? S_ISSUE : S_RESP;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (alu_ready_i || (tmr_q == '0)) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_mode_d = alu_mode_q;
        data_d     = data_q;
        err_d      = err_q;
        tout_d     = tout_q;
        tmr_d      = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    grant_d    = cand_idx;
                    alu_a_d    = a_arr[cand_idx];
                    alu_b_d    = b_arr[cand_idx];
                    alu_mode_d = mode_arr[cand_idx];
                    data_d     = '0;
                    err_d      = !cand_legal;
                    tout_d     = 1'b0;
                end
            end
            S_ISSUE: tmr_d = TMR_W'(TIMEOUT - 1);
            S_WAIT: begin
                // ready wins over expiry on the last watchdog cycle
                if (alu_ready_i) begin
                    data_d = alu_out_i;
                    err_d  = 1'b0;
                    tout_d = 1'b0;
                end else if (tmr_q == '0) begin
                    data_d = '0;
                    err_d  = 1'b1;
                    tout_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_RESP: rr_ptr_d = IDX_W'((int'(grant_q) + 1) % NUM_REQ);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_mode_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            tout_q     <= 1'b0;
            tmr_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_mode_q <= alu_mode_d;
            data_q     <= data_d;
            err_q      <= err_d;
            tout_q     <= tout_d;
            tmr_q      <= tmr_d;
        end
    end

    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        resp_data_o  = '0;
        resp_err_o   = 1'b0;
        alu_valid_o  = 1'b0;
        alu_a_o      = '0;
        alu_b_o      = '0;
        alu_mode_o   = '0;
        alu_rst_n_o  = 1'b0;
        if (!rst_i) begin
            if (handshake) req_ready_o[cand_idx] = 1'b1;
            alu_valid_o = (state_q == S_ISSUE);
            alu_a_o     = alu_a_q;
            alu_b_o     = alu_b_q;
            alu_mode_o  = alu_mode_q;
            alu_rst_n_o = 1'b1;
            if (state_q == S_RESP) begin
                resp_valid_o[grant_q] = 1'b1;
                resp_data_o           = data_q;
                resp_err_o            = err_q;
                alu_rst_n_o           = !tout_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed and random requests, a behavioural ALU with
// programmable latency, and a transaction-level reference of grant order and timing.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int TO = 40;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [4*N-1:0]  req_mode = '0;
    logic [N-1:0]    req_ready, resp_valid;
    logic [63:0]     resp_data;
    logic            resp_err, alu_valid, alu_rst_n;
    logic [31:0]     alu_a, alu_b;
    logic [3:0]      alu_mode;
    logic            alu_ready = 1'b0;
    logic [63:0]     alu_out = '0;

    alu_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_mode_i(req_mode),
        .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .resp_err_o(resp_err), .alu_valid_o(alu_valid), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_mode_o(alu_mode), .alu_rst_n_o(alu_rst_n), .alu_ready_i(alu_ready),
        .alu_out_i(alu_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  m;
        logic [7:0]  lat;   // 0 = ALU never answers
    } op_t;

    op_t ops [N][64];
    int  head [N];
    int  tail [N];

    int vectors = 0, miscompares = 0;
    int cyc = 0, busy_end = -1, rr = 0;
    int ev_valid = -1, ev_resp = -1, ev_rstlow = -1, ev_g = 0;
    logic [63:0] ev_data = '0;
    logic        ev_err = 1'b0;
    logic [31:0] lat_a = '0, lat_b = '0;
    logic [3:0]  lat_m = '0;

    int          alu_lat = 1, alu_left = 0;
    bit          alu_busy = 0, stray_ready = 0;
    logic [63:0] alu_res = '0;

    function automatic logic [63:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] m);
        case (m)
            4'd0:    return {32'b0, a} + {32'b0, b};
            4'd9:    return {32'b0, a} * {32'b0, b};
            4'd10:   return (b == 0) ? '1 : {a / b, a % b};
            default: return {a ^ b, a + b} ^ {60'b0, m};
        endcase
    endfunction

    // Behavioural ALU: ready is high during cycle C1+lat, i.e. lat cycles after the start pulse.
    always @(negedge clk) begin
        alu_ready = 1'b0;
        alu_out   = '0;
        if (!alu_rst_n) begin
            alu_busy = 0;
        end else if (alu_valid) begin
            alu_busy = (alu_lat != 0);
            alu_left = alu_lat;
            alu_res  = alu_fn(alu_a, alu_b, alu_mode);
        end else if (alu_busy) begin
            alu_left--;
            if (alu_left == 0) begin
                alu_ready = 1'b1;
                alu_out   = alu_res;
                alu_busy  = 0;
            end
        end else if (stray_ready) begin
            alu_ready = 1'b1;
            alu_out   = 64'hDEAD_BEEF_0BAD_F00D;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] m, input int lat);
        op_t o;
        o.a = a; o.b = b; o.m = m; o.lat = 8'(lat);
        ops[i][tail[i] % 64] = o;
        tail[i]++;
    endtask

    task automatic step();
        logic [N-1:0]  pend, e_ready, e_resp;
        logic [63:0]   e_data;
        logic          e_err, live;
        op_t           o;
        int            g, idx;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            pend[i] = (head[i] != tail[i]);
            o = ops[i][head[i] % 64];
            req_a[32*i +: 32]  = o.a;
            req_b[32*i +: 32]  = o.b;
            req_mode[4*i +: 4] = o.m;
        end
        req_valid = pend;
        #1;
        live    = !rst;
        g       = -1;
        e_ready = '0;
        if (live && cyc > busy_end && |pend) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && pend[idx]) g = idx;
            end
            e_ready[g] = 1'b1;
        end
        e_resp = '0;
        e_data = '0;
        e_err  = 1'b0;
        if (live && cyc == ev_resp) begin
            e_resp[ev_g] = 1'b1;
            e_data = ev_data;
            e_err  = ev_err;
        end
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("alu_valid", 64'(alu_valid), 64'(live && cyc == ev_valid));
        chk("resp_valid", 64'(resp_valid), 64'(e_resp));
        chk("resp_data", resp_data, e_data);
        chk("resp_err", 64'(resp_err), 64'(e_err));
        chk("alu_rst_n", 64'(alu_rst_n), 64'(live && cyc != ev_rstlow));
        chk("alu_a", 64'(alu_a), live ? 64'(lat_a) : 64'd0);
        chk("alu_b", 64'(alu_b), live ? 64'(lat_b) : 64'd0);
        chk("alu_mode", 64'(alu_mode), live ? 64'(lat_m) : 64'd0);
        if (!live) begin
            ev_valid = -1; ev_resp = -1; ev_rstlow = -1;
            busy_end = cyc; rr = 0;
            lat_a = '0; lat_b = '0; lat_m = '0;
        end else if (g >= 0) begin
            o = ops[g][head[g] % 64];
            head[g]++;
            rr = (g + 1) % N;
            ev_g = g;
            ev_rstlow = -1;
            if (o.m >= 4'd11) begin
                ev_valid = -1; ev_resp = cyc + 1; ev_data = '0; ev_err = 1'b1;
            end else if (o.lat == 0) begin
                ev_valid = cyc + 1; ev_resp = cyc + TO + 2; ev_data = '0; ev_err = 1'b1;
                ev_rstlow = ev_resp;
            end else begin
                ev_valid = cyc + 1; ev_resp = cyc + int'(o.lat) + 2;
                ev_data = alu_fn(o.a, o.b, o.m); ev_err = 1'b0;
            end
            busy_end = ev_resp;
            alu_lat  = int'(o.lat);
            lat_a = o.a; lat_b = o.b; lat_m = o.m;
        end
    endtask

    task automatic drain(input int max);
        int  n = 0;
        bit  done;
        done = 0;
        while (n < max && !done) begin
            step();
            n++;
            done = (cyc > busy_end);
            for (int i = 0; i < N; i++) if (head[i] != tail[i]) done = 0;
        end
        chk("drain_bound", 64'(done), 64'd1);
    endtask

    initial begin
        int          cnt, ri, rl;
        logic [3:0]  rm;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // single add, minimum ALU latency
        push(0, 32'd5, 32'd7, 4'd0, 1);
        drain(100);
        stray_ready = 1;
        repeat (3) step();
        stray_ready = 0;
        step();

        // all requesters busy: grants rotate 0,1,2,3,0,...
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++) push(i, $urandom, $urandom, 4'd2, $urandom_range(1, 5));
        drain(300);

        // illegal modes bypass the ALU and still advance the pointer
        push(2, $urandom, $urandom, 4'hB, 1);
        drain(50);
        push(0, $urandom, $urandom, 4'd1, 2);
        push(3, $urandom, $urandom, 4'hF, 1);
        drain(100);
        push(1, $urandom, $urandom, 4'd10, 34);
        drain(100);

        // hung ALU, recovery, and ready on the last watchdog cycle
        push(1, $urandom, $urandom, 4'd3, 0);
        drain(100);
        push(1, $urandom, $urandom, 4'd3, 2);
        drain(50);
        push(2, $urandom, $urandom, 4'd5, TO);
        drain(100);

        // result pass-through and mul latency
        push(0, 32'h7FFF_FFFF, 32'd1, 4'd0, 1);
        push(3, $urandom, $urandom, 4'd9, 34);
        drain(150);

        // random mix
        for (int r = 0; r < 8; r++) begin
            cnt = $urandom_range(1, 6);
            for (int j = 0; j < cnt; j++) begin
                ri = $urandom_range(0, N - 1);
                rm = 4'($urandom_range(0, 15));
                if (rm == 4'd9 || rm == 4'd10) rl = 34;
                else rl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
                push(ri, $urandom, $urandom, rm, rl);
            end
            drain(2000);
        end

        // reset in the middle of a mul: dropped, pointer back to 0
        push(0, $urandom, $urandom, 4'd9, 34);
        repeat (12) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        push(1, $urandom, $urandom, 4'd1, 2);
        push(3, $urandom, $urandom, 4'd1, 2);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
